br_pred_monitor: RTL
====================

BR_PRED_MONITOR -- requirements
Module: br_pred_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent prediction channels (ch0 conditional branch, ch1 jump/jalr).
REQ-002 SHALL have parameter CNT_W, default 32: width of cumulative counters.
REQ-003 SHALL have parameter WIN_LOG2, default 6: tumbling window length, WIN = 2^WIN_LOG2 events.
REQ-004 SHALL have parameter THRESH, default 8: mispredict count per window above which alarm asserts.
REQ-005 SHALL have port i_clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_is_br  in  N_CH  per-channel resolved-prediction strobe.
REQ-008 SHALL have port i_is_correct  in  N_CH  per-channel outcome, 1 = correct; ignored where i_is_br=0.
REQ-009 SHALL have port i_clr  in  1  synchronous clear of all counters, windows, alarms, sat flags.
REQ-010 SHALL have port i_snap_req  in  1  snapshot request pulse.
REQ-011 SHALL have port i_snap_rdy  in  1  consumer ready for snapshot.
REQ-012 SHALL have port o_total  out  N_CH*CNT_W  live event count per channel, ch0 in LSBs.
REQ-013 SHALL have port o_miss  out  N_CH*CNT_W  live mispredict count per channel.
REQ-014 SHALL have port o_snap_total / o_snap_miss  out  N_CH*CNT_W each  frozen copies.
REQ-015 SHALL have port o_snap_vld  out  1  snapshot valid.
REQ-016 SHALL have port o_win_done  out  N_CH  one-cycle pulse on window close.
REQ-017 SHALL have port o_alarm  out  N_CH  result of last closed window.
REQ-018 SHALL have port o_sat  out  N_CH  sticky: a counter of that channel saturated.

Function
REQ-019 Counters: per channel, i_is_br=1 increments total; additionally increments miss when i_is_correct=0; visible on o_total/o_miss one cycle after strobe edge.
REQ-020 Saturation: counters SHALL hold at 2^CNT_W-1, never wrap; o_sat[ch] sets same edge a counter reaches max, stays until clr/reset.
REQ-021 Channels fully independent; simultaneous strobes on all channels in one cycle all counted.
REQ-022 Window: per channel win_cnt (WIN_LOG2+1 bits) and win_miss; on the WIN-th event, at that edge o_alarm[ch] <= (win_miss incl. this event > THRESH), o_win_done[ch] pulses 1 cycle, win_cnt/win_miss restart at 0.
REQ-023 o_alarm[ch] SHALL hold value until next window close of that channel, clr, or reset.
REQ-024 Snapshot FSM states IDLE, HOLD; IDLE + i_snap_req -> capture live counters (values before this edge's updates), o_snap_vld=1, go HOLD.
REQ-025 HOLD: snapshot registers frozen; i_snap_req ignored; o_snap_vld && i_snap_rdy -> IDLE, o_snap_vld=0 next cycle.
REQ-026 i_snap_req and i_snap_rdy both high in IDLE: capture occurs, rdy not consumed (handshake needs o_snap_vld already 1).
REQ-027 i_clr wins over same-cycle strobes: counters, windows, o_sat, o_alarm, o_win_done go 0, events that cycle dropped.
REQ-028 i_clr with i_snap_req in IDLE: snapshot captures pre-clear values. i_clr in HOLD: snapshot registers and FSM unaffected.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 i_rst_n=0 SHALL asynchronously force all counters, window state, snapshot registers, o_snap_vld, o_win_done, o_alarm, o_sat to 0 and FSM to IDLE, regardless of clock.
REQ-031 Reset mid-HOLD SHALL drop snapshot; after release first request captures normally.

Verification
REQ-032 ch0 10 strobes, 3 with correct=0 -> o_total[ch0]=10, o_miss[ch0]=3; ch1 stays 0.
REQ-033 64 events ch0, 9 misses -> o_win_done[0] pulse on 64th, o_alarm[0]=1; next 64 with 8 misses -> o_alarm[0]=0.
REQ-034 CNT_W=4, 17 strobes ch1 -> o_total[ch1]=15, o_sat[1]=1; i_clr -> all 0.
REQ-035 snap_req at total=5, 3 more events, rdy held 0 for 4 cycles -> o_snap_total=5, o_snap_vld held; rdy=1 -> vld=0 next cycle; o_total=8.
REQ-036 i_clr + strobe same cycle -> o_total stays 0; i_clr + snap_req with total=7 -> o_snap_total=7, o_total=0.
REQ-037 Assert i_rst_n=0 between clock edges while HOLD with alarm=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/br_pred_monitor.sv
// Branch-prediction accuracy monitor: per-channel saturating event/mispredict counters,
// tumbling-window mispredict alarm, and a valid/ready snapshot of the live counters.
module br_pred_monitor #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 32,
  parameter int WIN_LOG2 = 6,
  parameter int THRESH   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_is_br,
  input  logic [N_CH-1:0]         i_is_correct,
  input  logic                    i_clr,
  input  logic                    i_snap_req,
  input  logic                    i_snap_rdy,
  output logic [N_CH*CNT_W-1:0]   o_total,
  output logic [N_CH*CNT_W-1:0]   o_miss,
  output logic [N_CH*CNT_W-1:0]   o_snap_total,
  output logic [N_CH*CNT_W-1:0]   o_snap_miss,
  output logic                    o_snap_vld,
  output logic [N_CH-1:0]         o_win_done,
  output logic [N_CH-1:0]         o_alarm,
  output logic [N_CH-1:0]         o_sat,
  output logic [0:0]              o_snap_state
);

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_PEN  = CNT_MAX - CNT_ONE;
  localparam logic [WIN_LOG2:0]   WIN_ONE  = (WIN_LOG2+1)'(1);
  localparam logic [WIN_LOG2:0]   WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Per-channel counters and window tracking; channels share nothing but clock and clear.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  miss_q;
    logic [WIN_LOG2:0] win_cnt_q;
    logic [WIN_LOG2:0] win_miss_q;
    logic [WIN_LOG2:0] win_miss_nxt;
    logic              miss_evt;
    logic              win_last;
    logic              done_q;
    logic              alarm_q;
    logic              sat_q;

    assign miss_evt     = i_is_br[ch] & ~i_is_correct[ch];
    assign win_miss_nxt = win_miss_q + (miss_evt ? WIN_ONE : '0);
    assign win_last     = (win_cnt_q == WIN_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        total_q    <= '0;
        miss_q     <= '0;
        win_cnt_q  <= '0;
        win_miss_q <= '0;
        done_q     <= 1'b0;
        alarm_q    <= 1'b0;
        sat_q      <= 1'b0;
      end else if (i_clr) begin
        total_q    <= '0;
        miss_q     <= '0;
        win_cnt_q  <= '0;
        win_miss_q <= '0;
        done_q     <= 1'b0;
        alarm_q    <= 1'b0;
        sat_q      <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (i_is_br[ch]) begin
          if (total_q != CNT_MAX) total_q <= total_q + CNT_ONE;
          if (miss_evt && (miss_q != CNT_MAX)) miss_q <= miss_q + CNT_ONE;
          // Flag on the edge that lands a counter on its maximum value.
          if ((total_q == CNT_PEN) || (miss_evt && (miss_q == CNT_PEN))) sat_q <= 1'b1;
          if (win_last) begin
            alarm_q    <= (int'(win_miss_nxt) > THRESH);
            done_q     <= 1'b1;
            win_cnt_q  <= '0;
            win_miss_q <= '0;
          end else begin
            win_cnt_q  <= win_cnt_q + WIN_ONE;
            win_miss_q <= win_miss_nxt;
          end
        end
      end
    end

    assign o_total[ch*CNT_W +: CNT_W] = total_q;
    assign o_miss[ch*CNT_W +: CNT_W]  = miss_q;
    assign o_win_done[ch]             = done_q;
    assign o_alarm[ch]                = alarm_q;
    assign o_sat[ch]                  = sat_q;
  end

  // Snapshot handshake: o_snap_vld is high exactly while in HOLD; a transfer happens
  // on a rising edge where o_snap_vld && i_snap_rdy, after which the FSM returns to IDLE.
  // Capture reads the registered live counters, so it sees pre-update (and pre-clear) values.
  logic [0:0]              state_q;
  logic [N_CH*CNT_W-1:0]   snap_total_q;
  logic [N_CH*CNT_W-1:0]   snap_miss_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      snap_total_q <= '0;
      snap_miss_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_snap_req) begin
            snap_total_q <= o_total;
            snap_miss_q  <= o_miss;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_snap_rdy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_snap_total = snap_total_q;
  assign o_snap_miss  = snap_miss_q;
  assign o_snap_vld   = (state_q == ST_HOLD);
  assign o_snap_state = state_q;

endmodule
